// File: rtl/led_cmd_pkg.sv
// Shared constants, types and helpers for the LED command register bank.
package led_cmd_pkg;

    localparam int NUM_LEDS      = 18;
    localparam int CMD_W         = 8;
    localparam int NUM_WORDS     = NUM_LEDS + 2;
    localparam int FCNT_W        = 8;

    localparam int OFF_CTRL      = 18;
    localparam int OFF_STATUS    = 19;

    localparam int CTRL_COMMIT   = 0;
    localparam int CTRL_CLEAR    = 1;

    localparam int STAT_PENDING  = 0;
    localparam int STAT_FADING   = 1;
    localparam int STAT_FCNT_LSB = 8;

    typedef logic [NUM_LEDS-1:0][CMD_W-1:0] led_bank_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_LED,
        ACC_CTRL,
        ACC_STATUS
    } acc_kind_t;

    // One fade step: move a byte one count toward its target, holding at equality.
    function automatic logic [CMD_W-1:0] step_toward(input logic [CMD_W-1:0] cur,
                                                     input logic [CMD_W-1:0] tgt);
        if (cur < tgt) return cur + CMD_W'(1);
        if (cur > tgt) return cur - CMD_W'(1);
        return cur;
    endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Frame prescaler: counts 0..FRAME_DIV-1, pulses frame_tick on the last count
// and keeps a free-running 8-bit frame counter.
module led_frame_timer
    import led_cmd_pkg::*;
#(
    parameter int FRAME_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    assign frame_tick  = (cnt_q == CNT_W'(FRAME_DIV - 1));
    assign frame_count = fcnt_q;

    always_comb begin
        cnt_d  = frame_tick ? '0 : cnt_q + CNT_W'(1);
        fcnt_d = frame_tick ? fcnt_q + FCNT_W'(1) : fcnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
        end
    end

endmodule

// File: rtl/led_cmd_regs.sv
// Memory-mapped LED command bank: shadow bytes committed atomically at frame ticks.
// Optional LED_CMD_FADE_EN: active bytes step one count per tick toward a target bank.
module led_cmd_regs
    import led_cmd_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'hF00,
    parameter int          FRAME_DIV = 50000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [11:0]               address,
    input  logic [31:0]               data,
    input  logic                      wren,
    output logic                      hit,
    output logic [31:0]               q,
    output logic [NUM_LEDS*CMD_W-1:0] led_commands,
    output logic                      frame_tick
);

    logic [11:0]       off_full;
    logic [4:0]        off;
    acc_kind_t         kind;
    logic [FCNT_W-1:0] frame_count;

    led_bank_t shadow_q, shadow_d;
    led_bank_t active_q, active_d;
    logic      pending_q, pending_d;
    logic      wr_led, wr_ctrl, commit_now, fading;
    logic [31:0] status;
    logic        unused_data;

    assign unused_data = ^data[31:CMD_W];

    // address >= BASE_ADDR guards the subtraction against wrap-around.
    assign off_full = address - BASE_ADDR;
    assign hit      = (address >= BASE_ADDR) && (off_full < 12'(NUM_WORDS));
    assign off      = off_full[4:0];

    always_comb begin
        kind = ACC_NONE;
        if (hit) begin
            if (off < 5'(NUM_LEDS))       kind = ACC_LED;
            else if (off == 5'(OFF_CTRL)) kind = ACC_CTRL;
            else                          kind = ACC_STATUS;
        end
    end

    led_frame_timer #(
        .FRAME_DIV (FRAME_DIV)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    assign wr_led     = wren && (kind == ACC_LED);
    assign wr_ctrl    = wren && (kind == ACC_CTRL);
    assign commit_now = frame_tick && pending_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_ctrl && data[CTRL_CLEAR]) shadow_d = '0;
        else if (wr_led)                 shadow_d[off] = data[CMD_W-1:0];
    end

    // A commit store always wins, so a store on a tick edge re-arms for the next tick.
    always_comb begin
        pending_d = pending_q;
        if (wr_ctrl && data[CTRL_COMMIT]) pending_d = 1'b1;
        else if (commit_now)              pending_d = 1'b0;
    end

`ifdef LED_CMD_FADE_EN
    led_bank_t target_q, target_d;

    always_comb begin
        target_d = commit_now ? shadow_q : target_q;
        active_d = active_q;
        if (frame_tick) begin
            for (int i = 0; i < NUM_LEDS; i++)
                active_d[i] = step_toward(active_q[i], target_d[i]);
        end
    end

    assign fading = (active_q != target_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) target_q <= '0;
        else        target_q <= target_d;
    end
`else
    always_comb begin
        active_d = commit_now ? shadow_q : active_q;
    end

    assign fading = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign led_commands = active_q;

    always_comb begin
        status = '0;
        status[STAT_PENDING]               = pending_q;
        status[STAT_FADING]                = fading;
        status[STAT_FCNT_LSB +: FCNT_W]    = frame_count;
    end

    always_comb begin
        case (kind)
            ACC_LED:    q = 32'(shadow_q[off]);
            ACC_STATUS: q = status;
            default:    q = '0;
        endcase
    end

endmodule
